// File: rtl/dsm2_bitstream_tx.sv
// PCM-to-bitstream transmitter: 2-deep sample FIFO, zero-order hold for OSR
// clocks, second-order error-feedback delta-sigma modulator, one bit per clock.
module dsm2_bitstream_tx #(
  parameter int WIDTH = 16,
  parameter int OSR   = 64,
  parameter int ACC_W = WIDTH + 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             underrun
);
  localparam int PH_W   = $clog2(OSR);
  localparam int WIDE_W = ACC_W + 3;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic signed [ACC_W-1:0]  FS_P = {{(ACC_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  FS_N = -FS_P;
  localparam logic signed [WIDE_W-1:0] ACC_MAX = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] ACC_MIN = {{(WIDE_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic signed [WIDE_W-1:0] sx(input logic signed [ACC_W-1:0] v);
    sx = {{(WIDE_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  state_t                   state_q, state_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic signed [WIDTH-1:0]  hold_q, hold_d;
  logic signed [ACC_W-1:0]  e1_q, e1_d, e2_q, e2_d;
  logic                     bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic                     frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [WIDTH-1:0]         fifo_mem_q [2];
  logic [WIDTH-1:0]         fifo_mem_d [2];
  logic                     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]               count_q, count_d;

  logic                     push, pop, fifo_empty;
  logic signed [ACC_W-1:0]  hold_ext, x, u, y, e;
  logic signed [WIDE_W-1:0] u_wide;
  logic                     q, sat_active;

  assign din_ready   = (count_q != 2'd2);
  assign fifo_empty  = (count_q == 2'd0);
  assign push        = din_valid && din_ready;
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  // Modulator datapath; u is computed wide so saturation can be detected.
  always_comb begin
    hold_ext = {{(ACC_W-WIDTH){hold_q[WIDTH-1]}}, hold_q};
    x        = hold_ext >>> 1;
    u_wide   = sx(x) - (sx(e1_q) <<< 1) + sx(e2_q);
    sat_active = (u_wide > ACC_MAX) || (u_wide < ACC_MIN);
    if (u_wide > ACC_MAX)      u = ACC_MAX[ACC_W-1:0];
    else if (u_wide < ACC_MIN) u = ACC_MIN[ACC_W-1:0];
    else                       u = u_wide[ACC_W-1:0];
    q = ~u[ACC_W-1];
    y = q ? FS_P : FS_N;
    // y always carries the sign of u, so e cannot overflow ACC_W.
    e = y - u;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d       = state_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    e1_d          = e1_q;
    e2_d          = e2_q;
    bit_out_d     = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_mem_q[rd_ptr_q];
          phase_d = '0;
          e1_d    = '0;
          e2_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          phase_d = '0;
          hold_d  = '0;
          e1_d    = '0;
          e2_d    = '0;
        end else begin
          bit_out_d     = q;
          bit_valid_d   = 1'b1;
          frame_start_d = (phase_q == '0);
          // A saturated loop is unstable; restarting the error history recovers it.
          e1_d = sat_active ? '0 : e;
          e2_d = sat_active ? '0 : e1_q;
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (fifo_empty) begin
              hold_d     = '0;
              underrun_d = 1'b1;
            end else begin
              pop    = 1'b1;
              hold_d = fifo_mem_q[rd_ptr_q];
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      hold_q        <= '0;
      e1_q          <= '0;
      e2_q          <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hold_q        <= hold_d;
      e1_q          <= e1_d;
      e2_q          <= e2_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: tb/tb_dsm2_bitstream_tx.sv
// Directed bench for dsm2_bitstream_tx (WIDTH=16, OSR=8): cycle tables for
// start-up, restart and reset, plus stream density and backpressure sequences.
module tb_dsm2_bitstream_tx;
  localparam int WIDTH = 16;
  localparam int OSR   = 8;

  logic             clk, reset, en, din_valid;
  logic [WIDTH-1:0] din;
  logic             din_ready, bit_out, bit_valid, frame_start, underrun;

  int n_cmp  = 0;
  int n_fail = 0;

  dsm2_bitstream_tx #(.WIDTH(WIDTH), .OSR(OSR), .ACC_W(WIDTH + 4)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             rst, en, dv;
    logic [WIDTH-1:0] din;
    logic             rdy, vld, bo, fs, ur;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] zpat;

  function automatic vec_t mk(input logic rst, input logic e, input logic dv,
                              input logic [WIDTH-1:0] d, input logic rdy,
                              input logic vld, input logic bo, input logic fs,
                              input logic ur);
    vec_t v;
    v.rst = rst; v.en = e; v.dv = dv; v.din = d;
    v.rdy = rdy; v.vld = vld; v.bo = bo; v.fs = fs; v.ur = ur;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic run_stream(input logic [WIDTH-1:0] val, input int lo, input int hi,
                            input string tag);
    int   nbits, ones, ur_cnt, sat_cnt;
    logic full_seen;
    nbits = 0; ones = 0; ur_cnt = 0; sat_cnt = 0; full_seen = 1'b0;
    reset = 1'b1; en = 1'b0; din_valid = 1'b0;
    step();
    reset = 1'b0; en = 1'b1; din_valid = 1'b1; din = val;
    for (int cyc = 0; cyc < 1500 && nbits < 1024; cyc++) begin
      step();
      if (bit_valid) begin
        nbits++;
        ones += int'(bit_out);
        if (underrun) ur_cnt++;
      end
      if (!din_ready) full_seen = 1'b1;
      if (dut.sat_active) sat_cnt++;
    end
    check({tag, " bit count"}, nbits, 1024);
    check_range({tag, " ones"}, ones, lo, hi);
    check({tag, " underruns"}, ur_cnt, 0);
    check({tag, " ready dropped when full"}, full_seen, 1);
    check({tag, " saturation cycles"}, sat_cnt, 0);
    en = 1'b0; din_valid = 1'b0;
  endtask

  // Backpressure bookkeeping
  int               bp_bits, bp_frames, bp_ur;
  logic             bp_ur_last;
  logic [WIDTH-1:0] bp_hold [3];

  task automatic bp_sample();
    if (bit_valid) begin
      bp_bits++;
      if (frame_start) begin
        if (bp_frames < 3) bp_hold[bp_frames] = dut.hold_q;
        bp_frames++;
      end
      if (underrun) begin
        bp_ur++;
        bp_ur_last = (bp_bits == 3 * OSR);
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;
    zpat = 4'b1001;

    // Reset, idle with en high, single zero sample, en drop.
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++)
      vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, zpat[i % 4], (i % OSR) == 0, i == OSR - 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0));
    // Two queued samples; en drops at phase 3 of the first, restart plays the second.
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h4000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, zpat[i % 4], (i % OSR) == 0, i == OSR - 1));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; en = vecs[i].en; din_valid = vecs[i].dv; din = vecs[i].din;
      step();
      check($sformatf("vec%0d din_ready", i),   din_ready,   vecs[i].rdy);
      check($sformatf("vec%0d bit_valid", i),   bit_valid,   vecs[i].vld);
      check($sformatf("vec%0d bit_out", i),     bit_out,     vecs[i].bo);
      check($sformatf("vec%0d frame_start", i), frame_start, vecs[i].fs);
      check($sformatf("vec%0d underrun", i),    underrun,    vecs[i].ur);
    end

    // Full-scale positive and negative streams.
    run_stream(16'h7FFF, 764, 772, "pos stream");
    run_stream(16'h8000, 252, 260, "neg stream");

    // Backpressure with en low, then three frames in order.
    reset = 1'b1; en = 1'b0; din_valid = 1'b0;
    step();
    reset = 1'b0;
    din_valid = 1'b1; din = 16'h1234;
    step();
    check("bp ready after A", din_ready, 1);
    din = 16'h2345;
    step();
    check("bp ready after B (full)", din_ready, 0);
    din = 16'h3456;
    step();
    check("bp C stalled", din_ready, 0);
    en = 1'b1;
    step();
    check("bp ready after load", din_ready, 1);
    check("bp valid at load", bit_valid, 0);
    check("bp loaded hold", dut.hold_q, 16'h1234);
    bp_bits = 0; bp_frames = 0; bp_ur = 0; bp_ur_last = 1'b0;
    step();
    check("bp C accepted (full)", din_ready, 0);
    bp_sample();
    din_valid = 1'b0;
    for (int cyc = 0; cyc < 100 && bp_bits < 3 * OSR; cyc++) begin
      step();
      bp_sample();
    end
    check("bp bit count", bp_bits, 3 * OSR);
    check("bp frame count", bp_frames, 3);
    check("bp frame0 sample", bp_hold[0], 16'h1234);
    check("bp frame1 sample", bp_hold[1], 16'h2345);
    check("bp frame2 sample", bp_hold[2], 16'h3456);
    check("bp underruns", bp_ur, 1);
    check("bp underrun on last bit", bp_ur_last, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
